// File: rtl/trace_checker.sv
// Lock-step trace checker: compares each CPU register-file commit against a FIFO of golden
// trace entries and reports pass/fail with the first mismatch captured.
module trace_checker #(
    parameter int unsigned DEPTH  = 8,
    parameter logic [31:0] END_PC = 32'h1c000100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] debug_wb_pc,
    input  logic [3:0]  debug_wb_rf_we,
    input  logic [4:0]  debug_wb_rf_wnum,
    input  logic [31:0] debug_wb_rf_wdata,
    input  logic        ref_valid,
    output logic        ref_ready,
    input  logic [31:0] ref_pc,
    input  logic [4:0]  ref_wnum,
    input  logic [31:0] ref_wdata,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        underflow,
    output logic [31:0] err_pc,
    output logic [31:0] err_exp_pc,
    output logic [4:0]  err_wnum,
    output logic [4:0]  err_exp_wnum,
    output logic [31:0] err_wdata,
    output logic [31:0] err_exp_wdata,
    output logic [31:0] commit_cnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StRun, StPass, StFail} state_e;

    state_e          state_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     commit_cnt_q, commit_cnt_d;
    logic            done_q, pass_q, fail_q, underflow_q;
    logic [31:0]     err_pc_q, err_exp_pc_q, err_wdata_q, err_exp_wdata_q;
    logic [4:0]      err_wnum_q, err_exp_wnum_q;

    logic [31:0]     mem_pc_q    [DEPTH];
    logic [4:0]      mem_wnum_q  [DEPTH];
    logic [31:0]     mem_wdata_q [DEPTH];

    logic            run, full, empty, push, commit, pop, match, err, at_end;
    logic [31:0]     head_pc, head_wdata;
    logic [4:0]      head_wnum;

    assign run       = (state_q == StRun);
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign ref_ready = run && !full;
    assign push      = ref_valid && ref_ready;
    assign commit    = run && (debug_wb_rf_we != 4'b0) && (debug_wb_rf_wnum != 5'd0);
    assign pop       = commit && !empty;

    assign head_pc    = mem_pc_q[rd_ptr_q];
    assign head_wnum  = mem_wnum_q[rd_ptr_q];
    assign head_wdata = mem_wdata_q[rd_ptr_q];

    assign match  = (head_pc == debug_wb_pc) && (head_wnum == debug_wb_rf_wnum) &&
                    (head_wdata == debug_wb_rf_wdata);
    // Empty FIFO on a commit is an underflow; a same-cycle push never satisfies it.
    assign err    = commit && (empty || !match);
    assign at_end = run && (debug_wb_pc == END_PC);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        commit_cnt_d = commit_cnt_q;
        if (pop && match) begin
            commit_cnt_d = commit_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]    <= ref_pc;
            mem_wnum_q[wr_ptr_q]  <= ref_wnum;
            mem_wdata_q[wr_ptr_q] <= ref_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StRun;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            commit_cnt_q    <= '0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            fail_q          <= 1'b0;
            underflow_q     <= 1'b0;
            err_pc_q        <= '0;
            err_exp_pc_q    <= '0;
            err_wnum_q      <= '0;
            err_exp_wnum_q  <= '0;
            err_wdata_q     <= '0;
            err_exp_wdata_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q      <= count_d;
            commit_cnt_q <= commit_cnt_d;
            // Errors outrank the end condition; only reachable from RUN, so first error sticks.
            if (err) begin
                state_q         <= StFail;
                done_q          <= 1'b1;
                fail_q          <= 1'b1;
                underflow_q     <= empty;
                err_pc_q        <= debug_wb_pc;
                err_wnum_q      <= debug_wb_rf_wnum;
                err_wdata_q     <= debug_wb_rf_wdata;
                err_exp_pc_q    <= empty ? 32'd0 : head_pc;
                err_exp_wnum_q  <= empty ? 5'd0 : head_wnum;
                err_exp_wdata_q <= empty ? 32'd0 : head_wdata;
            end else if (at_end) begin
                state_q <= StPass;
                done_q  <= 1'b1;
                pass_q  <= 1'b1;
            end
        end
    end

    assign done          = done_q;
    assign pass          = pass_q;
    assign fail          = fail_q;
    assign underflow     = underflow_q;
    assign err_pc        = err_pc_q;
    assign err_exp_pc    = err_exp_pc_q;
    assign err_wnum      = err_wnum_q;
    assign err_exp_wnum  = err_exp_wnum_q;
    assign err_wdata     = err_wdata_q;
    assign err_exp_wdata = err_exp_wdata_q;
    assign commit_cnt    = commit_cnt_q;

endmodule

// File: tb/tb_trace_checker.sv
// Directed self-checking bench for trace_checker with hand-computed expectations.
module tb_trace_checker;

    localparam logic [31:0] END_PC = 32'h1c000100;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        ref_valid;
    logic        ref_ready;
    logic [31:0] ref_pc;
    logic [4:0]  ref_wnum;
    logic [31:0] ref_wdata;
    logic        done, pass, fail, underflow;
    logic [31:0] err_pc, err_exp_pc, err_wdata, err_exp_wdata, commit_cnt;
    logic [4:0]  err_wnum, err_exp_wnum;

    int checks = 0;
    int errors = 0;

    trace_checker #(.DEPTH(8), .END_PC(END_PC)) dut (
        .clk(clk), .reset(reset),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_pc(ref_pc),
        .ref_wnum(ref_wnum), .ref_wdata(ref_wdata),
        .done(done), .pass(pass), .fail(fail), .underflow(underflow),
        .err_pc(err_pc), .err_exp_pc(err_exp_pc), .err_wnum(err_wnum),
        .err_exp_wnum(err_exp_wnum), .err_wdata(err_wdata), .err_exp_wdata(err_exp_wdata),
        .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_dbg(input logic [31:0] pc, input logic [3:0] we, input logic [4:0] wn,
                           input logic [31:0] wd);
        debug_wb_pc       = pc;
        debug_wb_rf_we    = we;
        debug_wb_rf_wnum  = wn;
        debug_wb_rf_wdata = wd;
    endtask

    task automatic set_ref(input logic v, input logic [31:0] pc, input logic [4:0] wn,
                           input logic [31:0] wd);
        ref_valid = v;
        ref_pc    = pc;
        ref_wnum  = wn;
        ref_wdata = wd;
    endtask

    task automatic push(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
        set_ref(1'b1, pc, wn, wd);
        tick();
        set_ref(1'b0, '0, '0, '0);
    endtask

    task automatic commit(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
        set_dbg(pc, 4'hf, wn, wd);
        tick();
        set_dbg('0, '0, '0, '0);
    endtask

    task automatic end_pc();
        set_dbg(END_PC, 4'h0, 5'd0, 32'd0);
        tick();
        set_dbg('0, '0, '0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] epc(input int i);
        return 32'h1c000000 + 32'(i * 4);
    endfunction

    function automatic logic [4:0] ewn(input int i);
        return 5'(i + 1);
    endfunction

    function automatic logic [31:0] ewd(input int i);
        return 32'(i + 100);
    endfunction

    initial begin
        reset = 1'b1;
        set_dbg('0, '0, '0, '0);
        set_ref(1'b0, '0, '0, '0);
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_ready", 32'(ref_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_cnt", commit_cnt, 32'd0);
        chk("rst_err_pc", err_pc, 32'd0);

        // Matching commits then end PC
        push(32'h1c000000, 5'd1, 32'd5);
        push(32'h1c000004, 5'd2, 32'd7);
        commit(32'h1c000000, 5'd1, 32'd5);
        commit(32'h1c000004, 5'd2, 32'd7);
        chk("match_cnt", commit_cnt, 32'd2);
        chk("match_fail", 32'(fail), 32'd0);
        chk("match_done_pre", 32'(done), 32'd0);
        end_pc();
        chk("end_done", 32'(done), 32'd1);
        chk("end_pass", 32'(pass), 32'd1);
        chk("end_fail", 32'(fail), 32'd0);
        chk("pass_ready", 32'(ref_ready), 32'd0);
        commit(32'h1c000008, 5'd3, 32'd9);
        chk("pass_cnt_frozen", commit_cnt, 32'd2);
        chk("pass_fail_stays", 32'(fail), 32'd0);

        // Filtered writes do not pop
        do_reset();
        push(32'h1c000000, 5'd1, 32'd5);
        set_dbg(32'h1c000000, 4'hf, 5'd0, 32'd5);
        tick();
        set_dbg(32'h1c000000, 4'h0, 5'd5, 32'd5);
        tick();
        set_dbg('0, '0, '0, '0);
        chk("filt_cnt", commit_cnt, 32'd0);
        chk("filt_fail", 32'(fail), 32'd0);
        commit(32'h1c000000, 5'd1, 32'd5);
        chk("filt_head_kept", commit_cnt, 32'd1);
        chk("filt_fail2", 32'(fail), 32'd0);

        // Data mismatch
        do_reset();
        push(32'h1c000000, 5'd3, 32'h10);
        commit(32'h1c000000, 5'd3, 32'h11);
        chk("mm_fail", 32'(fail), 32'd1);
        chk("mm_done", 32'(done), 32'd1);
        chk("mm_pass", 32'(pass), 32'd0);
        chk("mm_underflow", 32'(underflow), 32'd0);
        chk("mm_err_wdata", err_wdata, 32'h11);
        chk("mm_err_exp_wdata", err_exp_wdata, 32'h10);
        chk("mm_err_pc", err_pc, 32'h1c000000);
        chk("mm_err_exp_pc", err_exp_pc, 32'h1c000000);
        chk("mm_err_wnum", 32'(err_wnum), 32'd3);
        chk("mm_err_exp_wnum", 32'(err_exp_wnum), 32'd3);
        chk("mm_cnt", commit_cnt, 32'd0);
        chk("mm_ready", 32'(ref_ready), 32'd0);
        commit(32'h1c000040, 5'd7, 32'h99);
        end_pc();
        chk("mm_first_only", err_wdata, 32'h11);
        chk("mm_still_fail", 32'(fail), 32'd1);
        chk("mm_no_pass", 32'(pass), 32'd0);

        // Reset mid-test, then a fresh passing run
        do_reset();
        chk("rr_done", 32'(done), 32'd0);
        chk("rr_fail", 32'(fail), 32'd0);
        chk("rr_err_wdata", err_wdata, 32'd0);
        chk("rr_err_exp_wdata", err_exp_wdata, 32'd0);
        chk("rr_ready", 32'(ref_ready), 32'd1);
        push(32'h1c000000, 5'd1, 32'd5);
        commit(32'h1c000000, 5'd1, 32'd5);
        end_pc();
        chk("rr_cnt", commit_cnt, 32'd1);
        chk("rr_pass", 32'(pass), 32'd1);

        // Underflow with a simultaneous push
        do_reset();
        set_ref(1'b1, 32'h1c000000, 5'd4, 32'h44);
        set_dbg(32'h1c000000, 4'hf, 5'd4, 32'h44);
        tick();
        set_ref(1'b0, '0, '0, '0);
        set_dbg('0, '0, '0, '0);
        chk("uf_fail", 32'(fail), 32'd1);
        chk("uf_underflow", 32'(underflow), 32'd1);
        chk("uf_exp_pc", err_exp_pc, 32'd0);
        chk("uf_exp_wnum", 32'(err_exp_wnum), 32'd0);
        chk("uf_exp_wdata", err_exp_wdata, 32'd0);
        chk("uf_err_wdata", err_wdata, 32'h44);
        chk("uf_cnt", commit_cnt, 32'd0);

        // Full FIFO, pop frees a slot, pointer wrap
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push(epc(i), ewn(i), ewd(i));
        end
        chk("full_ready", 32'(ref_ready), 32'd0);
        set_ref(1'b1, epc(8), ewn(8), ewd(8));
        set_dbg(epc(0), 4'hf, ewn(0), ewd(0));
        tick();
        chk("full_pop_ready", 32'(ref_ready), 32'd1);
        chk("full_pop_cnt", commit_cnt, 32'd1);
        set_dbg(epc(1), 4'hf, ewn(1), ewd(1));
        tick();
        set_ref(1'b0, '0, '0, '0);
        set_dbg('0, '0, '0, '0);
        chk("pushpop_ready", 32'(ref_ready), 32'd1);
        chk("pushpop_cnt", commit_cnt, 32'd2);
        push(epc(9), ewn(9), ewd(9));
        chk("refull_ready", 32'(ref_ready), 32'd0);
        for (int i = 2; i < 10; i++) begin
            commit(epc(i), ewn(i), ewd(i));
        end
        chk("wrap_cnt", commit_cnt, 32'd10);
        chk("wrap_fail", 32'(fail), 32'd0);
        chk("wrap_ready", 32'(ref_ready), 32'd1);

        // Mismatching commit at END_PC: error wins
        push(END_PC, 5'd1, 32'd1);
        commit(END_PC, 5'd1, 32'd2);
        chk("endfail_fail", 32'(fail), 32'd1);
        chk("endfail_pass", 32'(pass), 32'd0);
        chk("endfail_err_pc", err_pc, END_PC);
        chk("endfail_cnt", commit_cnt, 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
